// File: rtl/sensor_sched.sv
// sensor_sched: arbitrates SR04/DHT11 measurements with periodic scheduling, timeouts and report handshake
module sensor_sched #(
    parameter int TICK_CYCLES     = 100_000,
    parameter int SR04_PERIOD_MS  = 100,
    parameter int DHT_PERIOD_MS   = 2000,
    parameter int SR04_TIMEOUT_MS = 40,
    parameter int DHT_TIMEOUT_MS  = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       auto_en,
    input  logic       man_sr04,
    input  logic       man_dht,
    input  logic       clr_fault,
    output logic       sr04_start,
    input  logic       sr04_done,
    output logic       dht_start,
    input  logic       dht_done,
    input  logic       dht_valid,
    output logic       report_req,
    output logic       report_sel,
    input  logic       report_ack,
    output logic       busy,
    output logic [1:0] fault
);
    typedef enum logic [2:0] {IDLE, SR_START, SR_WAIT, DHT_START, DHT_WAIT, REPORT} state_t;
    localparam int TW   = $clog2(TICK_CYCLES + 1);
    localparam int SW   = $clog2(SR04_PERIOD_MS + 1);
    localparam int DW   = $clog2(DHT_PERIOD_MS + 1);
    localparam int TMAX = SR04_TIMEOUT_MS > DHT_TIMEOUT_MS ? SR04_TIMEOUT_MS : DHT_TIMEOUT_MS;
    localparam int OW   = $clog2(TMAX + 1);
    state_t state, state_n;
    logic [TW-1:0] tcnt;
    logic [SW-1:0] sr_per;
    logic [DW-1:0] dht_per;
    logic [OW-1:0] to_cnt;
    logic tick, sr_exp, dht_exp, timeout, pend_sr, pend_dht, last_dht, waiting;
    logic [1:0] fault_set;
    assign tick       = tcnt == TW'(TICK_CYCLES - 1);
    assign sr_exp     = auto_en && tick && sr_per == SW'(SR04_PERIOD_MS - 1);
    assign dht_exp    = auto_en && tick && dht_per == DW'(DHT_PERIOD_MS - 1);
    assign waiting    = state == SR_WAIT || state == DHT_WAIT;
    assign timeout    = tick && (state == SR_WAIT ? to_cnt == OW'(SR04_TIMEOUT_MS - 1)
                                                  : to_cnt == OW'(DHT_TIMEOUT_MS - 1));
    assign sr04_start = state == SR_START;
    assign dht_start  = state == DHT_START;
    assign report_req = state == REPORT;
    assign busy       = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tcnt       <= '0;
            sr_per     <= '0;
            dht_per    <= '0;
            to_cnt     <= '0;
            pend_sr    <= 1'b0;
            pend_dht   <= 1'b0;
            last_dht   <= 1'b1;
            report_sel <= 1'b0;
            fault      <= 2'b00;
        end else begin
            state      <= state_n;
            tcnt       <= tick ? '0 : tcnt + TW'(1);
            sr_per     <= (!auto_en || sr_exp) ? '0 : sr_per + SW'(tick);
            dht_per    <= (!auto_en || dht_exp) ? '0 : dht_per + DW'(tick);
            to_cnt     <= (sr04_start || dht_start) ? '0 : to_cnt + OW'(tick && waiting);
            // a request landing on the start cycle survives, giving one follow-up run
            pend_sr    <= (pend_sr && !sr04_start) || man_sr04 || sr_exp;
            pend_dht   <= (pend_dht && !dht_start) || man_dht || dht_exp;
            last_dht   <= sr04_start ? 1'b0 : dht_start ? 1'b1 : last_dht;
            report_sel <= (state_n == REPORT && state != REPORT) ? state == DHT_WAIT : report_sel;
            fault      <= (clr_fault ? 2'b00 : fault) | fault_set;
        end
    end
    always_comb begin
        state_n   = state;
        fault_set = 2'b00;
        case (state)
            IDLE:      state_n = (pend_sr && (!pend_dht || last_dht)) ? SR_START
                               : pend_dht ? DHT_START : IDLE;
            SR_START:  state_n = SR_WAIT;
            DHT_START: state_n = DHT_WAIT;
            SR_WAIT: begin
                state_n      = sr04_done ? REPORT : timeout ? IDLE : SR_WAIT;
                fault_set[0] = !sr04_done && timeout;
            end
            DHT_WAIT: begin
                state_n      = dht_done ? (dht_valid ? REPORT : IDLE) : timeout ? IDLE : DHT_WAIT;
                fault_set[1] = dht_done ? !dht_valid : timeout;
            end
            REPORT:    state_n = report_ack ? IDLE : REPORT;
            default:   state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sensor_sched.sv
// tb_sensor_sched: directed scenario bench for sensor_sched
module tb_sensor_sched;
    logic clk = 1'b0;
    logic rst, auto_en, man_sr04, man_dht, clr_fault, sr04_done, dht_done, dht_valid, report_ack;
    logic sr04_start, dht_start, report_req, report_sel, busy;
    logic [1:0] fault;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    always #5 clk = ~clk;
    sensor_sched #(
        .TICK_CYCLES(10), .SR04_PERIOD_MS(5), .DHT_PERIOD_MS(12),
        .SR04_TIMEOUT_MS(4), .DHT_TIMEOUT_MS(4)
    ) dut (
        .clk(clk), .rst(rst), .auto_en(auto_en), .man_sr04(man_sr04), .man_dht(man_dht),
        .clr_fault(clr_fault), .sr04_start(sr04_start), .sr04_done(sr04_done),
        .dht_start(dht_start), .dht_done(dht_done), .dht_valid(dht_valid),
        .report_req(report_req), .report_sel(report_sel), .report_ack(report_ack),
        .busy(busy), .fault(fault)
    );
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask
    task automatic go(input int n);
        while (cyc < n) step();
    endtask
    task automatic clear_in();
        auto_en = 0; man_sr04 = 0; man_dht = 0; clr_fault = 0;
        sr04_done = 0; dht_done = 0; dht_valid = 0; report_ack = 0;
    endtask
    task automatic do_reset();
        rst = 1;
        clear_in();
        step();
        step();
        rst = 0;
        cyc = 0;
    endtask
    task automatic test_reset();
        rst = 1; clear_in(); man_sr04 = 1; man_dht = 1;
        step(); step(); step();
        rst = 0; man_sr04 = 0; man_dht = 0; cyc = 0;
        for (int i = 0; i < 4; i++) begin
            total++; if ({sr04_start, dht_start, report_req, busy, report_sel, fault} !== 7'b0) begin bad++; $display("FAIL reset_outs cyc=%0d got=%b want=0", cyc, {sr04_start, dht_start, report_req, busy, report_sel, fault}); end
            step();
        end
    endtask
    task automatic test_manual_sr04();
        int starts = 0;
        int first = -1;
        do_reset();
        go(20); man_sr04 = 1; step(); man_sr04 = 0;
        while (cyc < 52) begin
            if (sr04_start) begin starts++; if (first < 0) first = cyc; end
            step();
        end
        total++; if (first !== 22) begin bad++; $display("FAIL man_start_cycle got=%0d want=22", first); end
        total++; if (starts !== 1) begin bad++; $display("FAIL man_start_count got=%0d want=1", starts); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL man_busy_wait got=%b want=1", busy); end
        sr04_done = 1; step(); sr04_done = 0;
        while (cyc <= 56) begin
            total++; if ({report_req, report_sel} !== 2'b10) begin bad++; $display("FAIL man_report cyc=%0d got=%b want=10", cyc, {report_req, report_sel}); end
            report_ack = (cyc == 56);
            step();
        end
        report_ack = 0;
        total++; if ({report_req, busy} !== 2'b00) begin bad++; $display("FAIL man_release got=%b want=00", {report_req, busy}); end
    endtask
    task automatic test_tie();
        do_reset();
        go(5); man_sr04 = 1; man_dht = 1; step(); man_sr04 = 0; man_dht = 0;
        step();
        total++; if ({sr04_start, dht_start} !== 2'b10) begin bad++; $display("FAIL tie_first got=%b want=10", {sr04_start, dht_start}); end
        go(10); sr04_done = 1; step(); sr04_done = 0;
        total++; if ({report_req, report_sel} !== 2'b10) begin bad++; $display("FAIL tie_sr_report got=%b want=10", {report_req, report_sel}); end
        step(); report_ack = 1; step(); report_ack = 0;
        total++; if ({dht_start, busy} !== 2'b00) begin bad++; $display("FAIL tie_idle_gap got=%b want=00", {dht_start, busy}); end
        step();
        total++; if ({sr04_start, dht_start} !== 2'b01) begin bad++; $display("FAIL tie_second got=%b want=01", {sr04_start, dht_start}); end
        go(17); dht_done = 1; dht_valid = 1; step(); dht_done = 0; dht_valid = 0;
        total++; if ({report_req, report_sel} !== 2'b11) begin bad++; $display("FAIL tie_dht_report got=%b want=11", {report_req, report_sel}); end
        report_ack = 1; step(); report_ack = 0;
        total++; if ({report_req, busy} !== 2'b00) begin bad++; $display("FAIL tie_release got=%b want=00", {report_req, busy}); end
    endtask
    task automatic test_timeout();
        int reqs = 0;
        do_reset();
        go(3); man_dht = 1; step(); man_dht = 0;
        step();
        total++; if (dht_start !== 1'b1) begin bad++; $display("FAIL to_start got=%b want=1", dht_start); end
        while (cyc < 39) begin reqs += int'(report_req); step(); end
        total++; if ({busy, fault} !== 3'b100) begin bad++; $display("FAIL to_before got=%b want=100", {busy, fault}); end
        step();
        total++; if ({busy, fault} !== 3'b010) begin bad++; $display("FAIL to_expire got=%b want=010", {busy, fault}); end
        total++; if (reqs !== 0) begin bad++; $display("FAIL to_no_report got=%0d want=0", reqs); end
        go(45); clr_fault = 1; step(); clr_fault = 0;
        total++; if (fault !== 2'b00) begin bad++; $display("FAIL to_clear got=%b want=00", fault); end
    endtask
    task automatic test_checksum();
        do_reset();
        go(3); man_dht = 1; step(); man_dht = 0;
        go(8); dht_done = 1; dht_valid = 0; clr_fault = 1; step(); dht_done = 0; clr_fault = 0;
        total++; if (fault !== 2'b10) begin bad++; $display("FAIL cs_fault_set_wins got=%b want=10", fault); end
        total++; if ({busy, report_req} !== 2'b00) begin bad++; $display("FAIL cs_no_report got=%b want=00", {busy, report_req}); end
        go(12); man_dht = 1; step(); man_dht = 0;
        step();
        total++; if (dht_start !== 1'b1) begin bad++; $display("FAIL cs_restart got=%b want=1", dht_start); end
        go(16); dht_done = 1; dht_valid = 1; step(); dht_done = 0; dht_valid = 0;
        total++; if ({report_req, report_sel, fault} !== 4'b1110) begin bad++; $display("FAIL cs_good_report got=%b want=1110", {report_req, report_sel, fault}); end
        report_ack = 1; step(); report_ack = 0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL cs_release got=%b want=0", busy); end
    endtask
    task automatic test_auto();
        int srn = 0, dhtn = 0, sr_first = -1, dht_first = -1;
        int sr_due = -1, dht_due = -1, overlap = 0, late = 0;
        do_reset();
        while (cyc < 520) begin
            if (sr04_start) begin srn++; if (sr_first < 0) sr_first = cyc; sr_due = cyc + 10; if (cyc >= 305) late++; end
            if (dht_start) begin dhtn++; if (dht_first < 0) dht_first = cyc; dht_due = cyc + 10; if (cyc >= 305) late++; end
            if (sr04_start && dht_start) overlap++;
            auto_en = cyc >= 5 && cyc < 305;
            sr04_done = cyc == sr_due;
            dht_done = cyc == dht_due;
            dht_valid = 1;
            report_ack = report_req;
            step();
        end
        clear_in();
        total++; if (sr_first !== 51) begin bad++; $display("FAIL auto_sr_first got=%0d want=51", sr_first); end
        total++; if (dht_first !== 121) begin bad++; $display("FAIL auto_dht_first got=%0d want=121", dht_first); end
        total++; if (srn !== 6) begin bad++; $display("FAIL auto_sr_count got=%0d want=6", srn); end
        total++; if (dhtn !== 2) begin bad++; $display("FAIL auto_dht_count got=%0d want=2", dhtn); end
        total++; if (overlap !== 0) begin bad++; $display("FAIL auto_overlap got=%0d want=0", overlap); end
        total++; if (late !== 0) begin bad++; $display("FAIL auto_after_disable got=%0d want=0", late); end
    endtask
    task automatic test_reset_mid();
        do_reset();
        go(3); man_sr04 = 1; step(); man_sr04 = 0;
        go(10);
        total++; if ({busy, sr04_start} !== 2'b10) begin bad++; $display("FAIL rm_in_wait got=%b want=10", {busy, sr04_start}); end
        rst = 1; step(); rst = 0;
        sr04_done = 1; report_ack = 1;
        while (cyc <= 20) begin
            total++; if ({sr04_start, dht_start, report_req, busy, report_sel, fault} !== 7'b0) begin bad++; $display("FAIL rm_outs cyc=%0d got=%b want=0", cyc, {sr04_start, dht_start, report_req, busy, report_sel, fault}); end
            step();
            sr04_done = 0; report_ack = 0;
        end
    endtask
    initial begin
        rst = 1;
        clear_in();
        test_reset();
        test_manual_sr04();
        test_tie();
        test_timeout();
        test_checksum();
        test_auto();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sensor_sched.md
# sensor_sched

Sequencer that shares the ultrasonic (SR04) and humidity/temperature (DHT11) measurement engines. It issues start pulses on manual request or on an automatic periodic schedule, and guarantees that only one sensor runs at a time. It applies a per-measurement timeout and hands each good result to the UART reporting path through a req/ack handshake. It sits between the button/UART command decode and the sr04/dht11 controllers in the top level.

## Interface

Parameters:
- `TICK_CYCLES`, default 100_000: clk cycles per 1 ms scheduler tick. Benches override it to a small value.
- `SR04_PERIOD_MS`, default 100: auto-run interval for SR04, in ticks.
- `DHT_PERIOD_MS`, default 2000: auto-run interval for DHT11, in ticks.
- `SR04_TIMEOUT_MS`, default 40: maximum wait for `sr04_done`.
- `DHT_TIMEOUT_MS`, default 30: maximum wait for `dht_done`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`, in, 1: system clock.
  - `rst`, in, 1: synchronous, active-high reset.
- `auto_en`, in, 1: level; enables periodic scheduling.
- `man_sr04`, in, 1: one-cycle pulse; manual SR04 request.
- `man_dht`, in, 1: one-cycle pulse; manual DHT11 request.
- `clr_fault`, in, 1: one-cycle pulse; clears `fault`.
- `sr04_start`, out, 1: one-cycle start pulse to the SR04 controller.
- `sr04_done`, in, 1: one-cycle pulse; SR04 distance valid.
- `dht_start`, out, 1: one-cycle start pulse to the DHT11 controller.
- `dht_done`, in, 1: one-cycle pulse; DHT11 frame received.
- `dht_valid`, in, 1: checksum OK. Sampled only when `dht_done` is high.
- `report_req`, out, 1: result ready for the UART sender.
- `report_sel`, out, 1: source of the report; 0 = SR04, 1 = DHT11. Stable while `report_req` is high.
- `report_ack`, in, 1: one-cycle pulse from the UART sender.
- `busy`, out, 1: high in every state except IDLE.
- `fault`, out, 2: sticky error flags. Bit 0 = SR04 timeout. Bit 1 = DHT11 timeout or checksum error.

## Operation

Tick generator:
- Free-running counter 0..TICK_CYCLES-1.
- `tick` is high for one cycle when the counter wraps.

Period counters (one per sensor):
- Count ticks only while `auto_en` = 1.
- On the tick where the count equals PERIOD_MS-1: set that sensor's pending flag and return the count to 0.
- `auto_en` = 0 holds both counts at 0. Re-enabling therefore restarts a full period.

Pending flags `pend_sr`, `pend_dht`:
- Set by a manual pulse or by period expiry.
- A request arriving while the flag is already set merges into it. There is no queue depth.
- A flag is cleared when its start pulse issues.
- A request arriving while that same sensor is measuring sets the flag again, so one follow-up measurement runs afterwards.

FSM states: IDLE, SR_START, SR_WAIT, DHT_START, DHT_WAIT, REPORT.
- IDLE:
  - Neither flag pending: stay in IDLE.
  - Only one flag pending: go to that sensor's START state.
  - Both pending: round-robin. Serve the sensor that was not served last. `last` resets to DHT, so SR04 wins the first tie.
- X_START:
  - Assert the sensor's start pulse for exactly one cycle.
  - Clear its pending flag, update `last`, clear the timeout counter.
  - Go to X_WAIT.
- X_WAIT (counts ticks):
  - Done pulse: SR04 goes to REPORT with `report_sel` = 0.
  - DHT with `dht_valid` = 1: go to REPORT with `report_sel` = 1.
  - DHT with `dht_valid` = 0: set `fault[1]` and go to IDLE.
  - Timeout count reaches TIMEOUT_MS with no done: set `fault[0]` or `fault[1]`, go to IDLE, no report.
  - Done and the timeout tick in the same cycle: done wins.
- REPORT:
  - Hold `report_req` = 1 until `report_ack` is sampled high.
  - Then go to IDLE. `report_req` drops in the following cycle.
  - Pending flags keep accumulating during REPORT, but no start issues.

Spurious inputs:
- Done pulses in any state other than the matching X_WAIT are ignored.
- `report_ack` outside REPORT is ignored.

`fault`:
- Bits are set by the error events above.
- Cleared by `clr_fault`.
- If set and clear land in the same cycle, set wins.

## Timing

- Reset values: `sr04_start`, `dht_start`, `report_req`, `busy` = 0; `report_sel` = 0; `fault` = 2'b00. State = IDLE, all counters = 0, both pending flags = 0, `last` = DHT.
- Reset is honoured in any state. A measurement in flight is abandoned and no start is re-issued.
- Start latency:
  - Manual pulse at cycle N sets the pending flag at N+1.
  - IDLE moves to START at N+2.
  - The start pulse is high during cycle N+2 only, decoded registered from the state.
- Done latency: done at cycle M gives REPORT with `report_req` = 1 at M+1.
- Back-to-back: after an ack at cycle K, IDLE at K+1, next START at K+2.
- Timeout resolution is one tick (±1 tick from the start pulse).

## Test plan

Bench override for all scenarios: TICK_CYCLES=10, SR04_PERIOD_MS=5, DHT_PERIOD_MS=12, both timeouts = 4.

1. Manual SR04 path:
   - Stimulus: `man_sr04` at cycle 20, `sr04_done` 30 cycles after the start pulse, ack 3 cycles after `report_req` rises.
   - Required: `sr04_start` is a single pulse at cycle 22; `report_req` = 1 with `report_sel` = 0 until the ack; `busy` returns to 0.
2. Tie arbitration:
   - Stimulus: `man_sr04` and `man_dht` in the same cycle, each sensor completes and each report is acked.
   - Required: SR04 is served first, then DHT11. `dht_start` issues exactly 2 cycles after the SR04 ack.
3. Timeout:
   - Stimulus: `man_dht`, never send `dht_done`.
   - Required: about 40 cycles after the start, `fault` = 2'b10, no `report_req`, FSM in IDLE. A later `clr_fault` pulse gives `fault` = 0.
4. Checksum failure:
   - Stimulus: `dht_done` with `dht_valid` = 0.
   - Required: `fault[1]` = 1, no report. A following `dht_done` with `dht_valid` = 1 reports with `report_sel` = 1.
5. Auto-run with immediately returning sensors:
   - Stimulus: `auto_en` = 1 for 300 cycles; sensors return done 1 tick after start.
   - Required: `sr04_start` every 50 cycles and `dht_start` every 120 cycles, never both active (`busy` gates). Dropping `auto_en` stops any new starts.
6. Reset mid-operation:
   - Stimulus: assert `rst` during SR_WAIT, then deliver `sr04_done`.
   - Required: all outputs 0, no report, done ignored.
